// File: rtl/bf16_mult_arbiter_if.sv
// ---------------------------------------------------------------------------
// bf16_mult_arbiter_if
//
// Bundles the requester-side handshakes and the shared-multiplier connection
// of bf16_mult_arbiter.
//
//   req_valid  [N_REQ]     requester i presents an operand pair
//   req_a/b    [N_REQ*16]  bf16 operands, lane i at [16i+15:16i]
//   req_ready  [N_REQ]     one-hot grant (accept = valid && ready)
//   resp_valid [N_REQ]     result slot i is full
//   resp_data  [N_REQ*16]  slot i product, same packing as req_a
//   resp_ready [N_REQ]     requester i consumes its result
//   mul_a/b    [16]        operands to the external multiplier
//   mul_c      [16]        product from the external multiplier
//
// Modports:
//   slave  - the arbiter itself
//   master - its environment: the requester lanes plus the multiplier
// ---------------------------------------------------------------------------
interface bf16_mult_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*16-1:0] req_a;
  logic [N_REQ*16-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    resp_valid;
  logic [N_REQ*16-1:0] resp_data;
  logic [N_REQ-1:0]    resp_ready;
  logic [15:0]         mul_a;
  logic [15:0]         mul_b;
  logic [15:0]         mul_c;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_c,
    output req_ready, resp_valid, resp_data, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_c,
    input  req_ready, resp_valid, resp_data, mul_a, mul_b
  );

endinterface

// File: rtl/bf16_mult_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_mult_arbiter
//
// Shares one registered bf16 multiplier (instantiated outside this block)
// among N_REQ requesters. Each cycle at most one eligible requester is
// granted in round-robin order; its operands are steered onto mul_a/mul_b
// and its ID travels down a LAT-deep tag pipeline alongside the multiplier.
// When the tag emerges, mul_c is captured into that requester's one-entry
// result slot and held there until the requester takes it.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - bf16_mult_arbiter_if.slave (request/response handshakes and the
//          multiplier operand/product wires)
//
// Parameters:
//   N_REQ - number of requesters, 2..8
//   LAT   - multiplier latency from operand sample edge to valid product, >=1
// ---------------------------------------------------------------------------
module bf16_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  bf16_mult_arbiter_if.slave        bus
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [IDW-1:0]   rr_reg;
  logic [IDW-1:0]   rr_next;
  logic [N_REQ-1:0] pending_reg;
  logic [N_REQ-1:0] pending_next;
  logic [N_REQ-1:0] resp_valid_reg;
  logic [N_REQ-1:0] resp_valid_next;
  logic [15:0]      slot_reg [N_REQ];

  logic             tag_vld_reg [LAT];
  logic [IDW-1:0]   tag_id_reg  [LAT];

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic             accept;
  logic [IDW-1:0]   gnt_id;
  int               idx;

  // A lane with an operation in flight or an unconsumed result is not
  // eligible. pending only clears on the handshake edge, so a lane is never
  // re-granted in the same cycle its result is taken.
  assign elig = bus.req_valid & ~pending_reg;

  // Scan from rr upward, wrapping; the first eligible lane wins. Only valid
  // and pending feed this, never the operand data, so req_ready has no path
  // from req_a/req_b.
  always_comb begin
    accept = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_reg) + k) % N_REQ;
      if (!accept && elig[idx[IDW-1:0]]) begin
        accept = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
    // Nothing may be granted while reset is held.
    if (rst) begin
      accept = 1'b0;
      gnt_id = '0;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant[gi] = accept && (gnt_id == IDW'(gi));
  end

  assign bus.req_ready = grant;

  // Pointer moves just past the lane that was accepted; unchanged otherwise.
  always_comb begin
    rr_next = rr_reg;
    if (accept) begin
      if (gnt_id == IDW'(N_REQ - 1)) begin
        rr_next = '0;
      end else begin
        rr_next = gnt_id + IDW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Issue: granted lane's operands, zero when idle.
  // -------------------------------------------------------------------------
  logic [15:0] mul_a_c;
  logic [15:0] mul_b_c;

  always_comb begin
    mul_a_c = 16'h0000;
    mul_b_c = 16'h0000;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        mul_a_c = bus.req_a[16*k +: 16];
        mul_b_c = bus.req_b[16*k +: 16];
      end
    end
  end

  assign bus.mul_a = mul_a_c;
  assign bus.mul_b = mul_b_c;

  // -------------------------------------------------------------------------
  // Tag pipeline: mirrors the multiplier's latency so the product that
  // appears on mul_c can be routed back to the lane that issued it.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (rst) begin
        tag_vld_reg[gi] <= 1'b0;
        tag_id_reg[gi]  <= '0;
      end else if (gi == 0) begin
        tag_vld_reg[gi] <= accept;
        tag_id_reg[gi]  <= gnt_id;
      end else begin
        tag_vld_reg[gi] <= tag_vld_reg[(gi > 0) ? gi - 1 : 0];
        tag_id_reg[gi]  <= tag_id_reg[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  logic           ret_vld;
  logic [IDW-1:0] ret_id;

  assign ret_vld = tag_vld_reg[LAT-1];
  assign ret_id  = tag_id_reg[LAT-1];

  // -------------------------------------------------------------------------
  // Result slots
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0] slot_we;
  logic [N_REQ-1:0] resp_hs;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign slot_we[gi] = ret_vld && (ret_id == IDW'(gi));
    assign resp_hs[gi] = resp_valid_reg[gi] && bus.resp_ready[gi];
    assign bus.resp_data[16*gi +: 16] = slot_reg[gi];
  end

  assign bus.resp_valid = resp_valid_reg;

  // A grant and a handshake never hit the same lane on one edge (grant needs
  // !pending, handshake needs a full slot, which implies pending). Likewise a
  // return and a handshake cannot coincide on a lane, since the return is
  // what fills the slot. The if/else ordering below is therefore only a
  // tie-break that never fires.
  always_comb begin
    pending_next    = pending_reg;
    resp_valid_next = resp_valid_reg;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        pending_next[k] = 1'b1;
      end else if (resp_hs[k]) begin
        pending_next[k] = 1'b0;
      end
      if (slot_we[k]) begin
        resp_valid_next[k] = 1'b1;
      end else if (resp_hs[k]) begin
        resp_valid_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg         <= '0;
      pending_reg    <= '0;
      resp_valid_reg <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        slot_reg[k] <= 16'h0000;
      end
    end else begin
      rr_reg         <= rr_next;
      pending_reg    <= pending_next;
      resp_valid_reg <= resp_valid_next;
      // Products are stored bit-exact; Inf/NaN/zero are not interpreted.
      for (int k = 0; k < N_REQ; k++) begin
        if (slot_we[k]) begin
          slot_reg[k] <= bus.mul_c;
        end
      end
      // A product returning to a lane whose slot is still full would be lost.
      if (ret_vld) begin
        assert (!resp_valid_reg[ret_id]);
      end
    end
  end

endmodule
